// File: rtl/button_irq_ctrl_if.sv
// Button interrupt controller bus: raw keys and enables in,
// one-at-a-time interrupt with identifying data word out.
interface button_irq_ctrl_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] buttons;
    logic [N_BTN-1:0] irq_en;
    logic             ack;
    logic             interrupt;
    logic [15:0]      data_reg;

    modport master (
        output buttons,
        output irq_en,
        output ack,
        input  interrupt,
        input  data_reg
    );

    modport slave (
        input  buttons,
        input  irq_en,
        input  ack,
        output interrupt,
        output data_reg
    );
endinterface

// File: rtl/button_irq_ctrl.sv
// Multi-channel debounced push-button interrupt source.
// Presses latch into pending bits; lowest pending channel is served first.
module button_irq_ctrl #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input logic             clk,
    input logic             rst,
    button_irq_ctrl_if.slave bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BTN-1:0] INACT = {N_BTN{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_GAP
    } state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] s_q;
    logic [N_BTN-1:0] deb_q;
    logic [N_BTN-1:0] deb_d;
    logic [N_BTN-1:0] deb_prev_q;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];

    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] pend_q;
    logic [N_BTN-1:0] pend_d;
    logic [N_BTN-1:0] clr;
    logic [N_BTN-1:0] sel_oh;
    logic [7:0]       sel_idx;
    logic             sel_found;
    logic [7:0]       pend8;

    state_e     state_q;
    logic       irq_q;
    logic [15:0] data_q;

    // Debounce: a level change is accepted after D stable cycles.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = s_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= INACT;
            s_q        <= INACT;
            deb_q      <= INACT;
            deb_prev_q <= INACT;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= bus.buttons;
            s_q        <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Inactive-to-active transition of the debounced level only.
    assign press = (deb_q ^ INACT) & ~(deb_prev_q ^ INACT);

    always_comb begin
        sel_oh    = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (pend_q[i] && !sel_found) begin
                sel_found  = 1'b1;
                sel_idx    = 8'(i);
                sel_oh[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        pend8 = '0;
        pend8[N_BTN-1:0] = pend_q;
    end

    assign clr = (state_q == S_IDLE) ? sel_oh : '0;

    // A press on the same edge as its clear wins; enable gates both.
    assign pend_d = ((pend_q & ~clr) | press) & bus.irq_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (sel_found) begin
                        data_q  <= {pend8, 8'(sel_idx + 8'd1)};
                        irq_q   <= 1'b1;
                        state_q <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (bus.ack) begin
                        irq_q   <= 1'b0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.interrupt = irq_q;
    assign bus.data_reg  = data_q;

endmodule
